// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: response-owner encoding,
// the default starvation limit and the read write-enable pattern.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_MEM  = 2'd2
    } owner_e;

    localparam int         STARVE_MAX_DEFAULT = 4;
    localparam int         STARVE_W           = 3;
    localparam logic [3:0] WEN_READ           = 4'b0000;

endpackage

// File: rtl/sram_starve_ctr.sv
// Saturating fetch-denial counter. clr has priority over inc; at_max flags
// that the fetch side has waited long enough to be forced through.
module sram_starve_ctr
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX = STARVE_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

    logic [STARVE_W-1:0] cnt_reg;
    logic [STARVE_W-1:0] cnt_next;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (inc && (cnt_reg != MAX_C)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign at_max = (cnt_reg == MAX_C);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and data memory.
// Data side has fixed priority; fetch is forced through after STARVE_MAX
// consecutive denials. The 1-cycle read return is routed to its owner.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    owner_e            owner_reg;
    owner_e            owner_next;
    logic [DATA_W-1:0] if_hold_reg;
    logic [DATA_W-1:0] mem_hold_reg;
    logic              starve_at_max;
    logic              starve_inc;

    // Fetch is denied whenever it asks and does not win; any other cycle
    // (granted or idle) breaks the run of denials.
    assign starve_inc = if_req && !if_gnt;

    sram_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clock  (clock),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (!starve_inc),
        .at_max (starve_at_max)
    );

    // Grant selection and SRAM drive; grants are suppressed while in reset.
    always_comb begin
        if_gnt     = 1'b0;
        mem_gnt    = 1'b0;
        sram_wen   = WEN_READ;
        sram_addr  = '0;
        sram_wdata = '0;
        if (reset) begin
            if (if_req && (!mem_req || starve_at_max)) begin
                if_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
        sram_en = if_gnt || mem_gnt;
        if (if_gnt) begin
            sram_addr = if_addr;
        end else if (mem_gnt) begin
            sram_wen   = mem_wen;
            sram_addr  = mem_addr;
            sram_wdata = mem_wdata;
        end
    end

    // Who owns next cycle's read data; writes return nothing.
    always_comb begin
        owner_next = OWN_NONE;
        if (if_gnt) begin
            owner_next = OWN_IF;
        end else if (mem_gnt && (mem_wen == WEN_READ)) begin
            owner_next = OWN_MEM;
        end
    end

    // Owner register; reset drops any response still in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner_reg <= OWN_NONE;
        end else begin
            owner_reg <= owner_next;
        end
    end

    assign if_rvalid  = (owner_reg == OWN_IF);
    assign mem_rvalid = (owner_reg == OWN_MEM);

    // Capture returned data so each side keeps its last value between reads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_hold_reg  <= '0;
            mem_hold_reg <= '0;
        end else begin
            if (if_rvalid) begin
                if_hold_reg <= sram_rdata;
            end
            if (mem_rvalid) begin
                mem_hold_reg <= sram_rdata;
            end
        end
    end

    assign if_rdata  = if_rvalid  ? sram_rdata : if_hold_reg;
    assign mem_rdata = mem_rvalid ? sram_rdata : mem_hold_reg;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios followed by a
// randomized run checked against a cycle-level behavioural model.
module tb_sram_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          mem_req;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          sram_en;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;

    int checks   = 0;
    int failures = 0;

    sram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SM)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .sram_en    (sram_en),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 time unit later, well away from either edge.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        if_req     = 1'b0;
        if_addr    = '0;
        mem_req    = 1'b0;
        mem_wen    = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        sram_rdata = $urandom;
    endtask

    function automatic logic [2*DW+3*AW+12:0] all_outputs();
        return {if_gnt, if_rvalid, if_rdata, mem_gnt, mem_rvalid, mem_rdata,
                sram_en, sram_wen, sram_addr, sram_wdata, 3'b000};
    endfunction

    task automatic test_reset();
        if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_wen = 4'b1111;
        mem_addr = 32'h80; mem_wdata = 32'hFFFF_FFFF; sram_rdata = 32'hA5A5_A5A5;
        for (int c = 0; c < 2; c++) begin
            next_cycle(); settle();
            checks++;
            if (all_outputs() !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d outputs=%h required=0", c, all_outputs());
            end
        end
        next_cycle();
        idle();
        reset = 1'b1;
        settle();
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL reset_release outputs=%h required=0", all_outputs());
        end
        $display("test_reset done");
    endtask

    task automatic test_fetch_read();
        next_cycle();
        idle();
        if_req = 1'b1; if_addr = 32'h0000_0040;
        settle();
        checks++;
        if ({if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata} !== {3'b101, 4'b0000, 32'h40, 32'h0}) begin
            failures++;
            $display("FAIL fetch_grant if_gnt=%b mem_gnt=%b en=%b wen=%b addr=%h wdata=%h required 1 0 1 0000 40 0",
                     if_gnt, mem_gnt, sram_en, sram_wen, sram_addr, sram_wdata);
        end
        next_cycle();
        idle();
        sram_rdata = 32'h2400_0001;
        settle();
        checks++;
        if ({if_rvalid, mem_rvalid, if_rdata} !== {2'b10, 32'h2400_0001}) begin
            failures++;
            $display("FAIL fetch_return if_rvalid=%b mem_rvalid=%b if_rdata=%h required 1 0 24000001",
                     if_rvalid, mem_rvalid, if_rdata);
        end
        next_cycle();
        sram_rdata = 32'h5555_0000;
        settle();
        checks++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'h2400_0001}) begin
            failures++;
            $display("FAIL fetch_hold if_rvalid=%b if_rdata=%h required 0 24000001", if_rvalid, if_rdata);
        end
        $display("test_fetch_read done");
    endtask

    task automatic test_starvation();
        logic exp_if;
        next_cycle();
        idle();
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h300;
        for (int c = 1; c <= 2 * (SM + 1); c++) begin
            if (c > 1) next_cycle();
            settle();
            exp_if = (c % (SM + 1)) == 0;
            checks++;
            if ({if_gnt, mem_gnt} !== {exp_if, !exp_if}) begin
                failures++;
                $display("FAIL starve_grant cyc=%0d if_gnt=%b mem_gnt=%b required %b %b",
                         c, if_gnt, mem_gnt, exp_if, !exp_if);
            end
        end
        $display("test_starvation done");
    endtask

    task automatic test_write_then_read();
        next_cycle();
        idle();
        mem_req = 1'b1; mem_wen = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'h1234_5678;
        settle();
        checks++;
        if ({mem_gnt, if_gnt, sram_en, sram_wen, sram_addr, sram_wdata} !== {3'b101, 4'b0011, 32'h100, 32'h1234_5678}) begin
            failures++;
            $display("FAIL write_drive gnt=%b/%b en=%b wen=%b addr=%h wdata=%h required 1/0 1 0011 100 12345678",
                     mem_gnt, if_gnt, sram_en, sram_wen, sram_addr, sram_wdata);
        end
        next_cycle();
        mem_wen = 4'b0000; mem_wdata = 32'h0;
        settle();
        checks++;
        if ({mem_rvalid, if_rvalid, mem_gnt, sram_wen} !== {3'b001, 4'b0000}) begin
            failures++;
            $display("FAIL write_no_resp mem_rvalid=%b if_rvalid=%b mem_gnt=%b wen=%b required 0 0 1 0000",
                     mem_rvalid, if_rvalid, mem_gnt, sram_wen);
        end
        next_cycle();
        idle();
        sram_rdata = 32'h0000_5678;
        settle();
        checks++;
        if ({mem_rvalid, mem_rdata} !== {1'b1, 32'h0000_5678}) begin
            failures++;
            $display("FAIL read_after_write mem_rvalid=%b mem_rdata=%h required 1 00005678", mem_rvalid, mem_rdata);
        end
        $display("test_write_then_read done");
    endtask

    task automatic test_alternating();
        logic [DW-1:0] d [0:9];
        int            s;
        next_cycle();
        idle();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            idle();
            s = i % 2;
            d[i] = $urandom;
            sram_rdata = d[i];
            if (i < 8) begin
                if (s == 0) begin if_req = 1'b1; if_addr = $urandom; end
                else begin mem_req = 1'b1; mem_addr = $urandom; end
            end
            settle();
            if (i < 8) begin
                checks++;
                if ({if_gnt, mem_gnt} !== {s == 0, s == 1}) begin
                    failures++;
                    $display("FAIL alt_grant i=%0d if_gnt=%b mem_gnt=%b required %b %b", i, if_gnt, mem_gnt, s == 0, s == 1);
                end
            end
            if (i > 0 && i < 9) begin
                checks++;
                if ({if_rvalid, mem_rvalid} !== {s == 1, s == 0}) begin
                    failures++;
                    $display("FAIL alt_rvalid i=%0d if_rvalid=%b mem_rvalid=%b required %b %b", i, if_rvalid, mem_rvalid, s == 1, s == 0);
                end
                checks++;
                if ((s == 1 ? if_rdata : mem_rdata) !== d[i]) begin
                    failures++;
                    $display("FAIL alt_rdata i=%0d rdata=%h required %h", i, (s == 1 ? if_rdata : mem_rdata), d[i]);
                end
            end
            if (i > 1) begin
                checks++;
                if ((s == 0 ? if_rdata : mem_rdata) !== d[i-1]) begin
                    failures++;
                    $display("FAIL alt_hold i=%0d rdata=%h required %h", i, (s == 0 ? if_rdata : mem_rdata), d[i-1]);
                end
            end
        end
        $display("test_alternating done");
    endtask

    task automatic test_reset_pending();
        next_cycle();
        idle();
        if_req = 1'b1; if_addr = 32'h80;
        settle();
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL pend_grant if_gnt=%b required 1", if_gnt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({if_gnt, sram_en, if_rdata, mem_rdata} !== '0) begin
            failures++;
            $display("FAIL pend_reset_now if_gnt=%b en=%b if_rdata=%h mem_rdata=%h required 0", if_gnt, sram_en, if_rdata, mem_rdata);
        end
        next_cycle();
        if_req = 1'b0;
        sram_rdata = 32'hCAFE_0001;
        settle();
        checks++;
        if ({if_rvalid, mem_rvalid, if_rdata, mem_rdata} !== '0) begin
            failures++;
            $display("FAIL pend_discard if_rvalid=%b mem_rvalid=%b if_rdata=%h mem_rdata=%h required 0",
                     if_rvalid, mem_rvalid, if_rdata, mem_rdata);
        end
        next_cycle();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) next_cycle();
            sram_rdata = $urandom | 32'h1;
            settle();
            checks++;
            if (all_outputs() !== '0) begin
                failures++;
                $display("FAIL pend_after_release cyc=%0d outputs=%h required 0", c, all_outputs());
            end
        end
        $display("test_reset_pending done");
    endtask

    task automatic test_fetch_only();
        next_cycle();
        idle();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            if_req = 1'b1;
            if_addr = 32'h1000 + 32'(4 * c);
            settle();
            checks++;
            if ({if_gnt, mem_gnt, sram_en, if_rvalid} !== {3'b101, c > 0}) begin
                failures++;
                $display("FAIL fetch_only cyc=%0d if_gnt=%b mem_gnt=%b en=%b if_rvalid=%b required 1 0 1 %b",
                         c, if_gnt, mem_gnt, sram_en, if_rvalid, c > 0);
            end
        end
        // With the denial count at zero, a contested cycle goes to data.
        next_cycle();
        mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h44;
        settle();
        checks++;
        if ({if_gnt, mem_gnt} !== 2'b01) begin
            failures++;
            $display("FAIL fetch_only_then_both if_gnt=%b mem_gnt=%b required 0 1", if_gnt, mem_gnt);
        end
        $display("test_fetch_only done");
    endtask

    task automatic test_random(input int n);
        int            st;
        int            own;
        logic [DW-1:0] hi, hm;
        logic          e_ig, e_mg, e_iv, e_mv;
        logic [3:0]    e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_ird, e_mrd;
        next_cycle();
        idle();
        reset = 1'b0;
        st = 0; own = 0; hi = '0; hm = '0;
        for (int c = 0; c < n; c++) begin
            next_cycle();
            reset      = ($urandom_range(0, 49) != 0);
            if_req     = ($urandom_range(0, 9) < 7);
            if_addr    = $urandom;
            mem_req    = ($urandom_range(0, 9) < 7);
            mem_wen    = $urandom_range(0, 1) ? 4'b0000 : 4'($urandom);
            mem_addr   = $urandom;
            mem_wdata  = $urandom;
            sram_rdata = $urandom;
            settle();
            if (!reset) begin
                st = 0; own = 0; hi = '0; hm = '0;
            end
            e_ig   = reset && if_req && (!mem_req || st == SM);
            e_mg   = reset && mem_req && !e_ig;
            e_wen  = e_mg ? mem_wen : 4'b0000;
            e_addr = e_ig ? if_addr : (e_mg ? mem_addr : '0);
            e_wd   = e_mg ? mem_wdata : '0;
            e_iv   = (own == 1);
            e_mv   = (own == 2);
            e_ird  = e_iv ? sram_rdata : hi;
            e_mrd  = e_mv ? sram_rdata : hm;
            checks++;
            if ({if_gnt, mem_gnt} !== {e_ig, e_mg}) begin
                failures++;
                $display("FAIL rnd_grant cyc=%0d if_gnt=%b mem_gnt=%b required %b %b", c, if_gnt, mem_gnt, e_ig, e_mg);
            end
            checks++;
            if ({sram_en, sram_wen, sram_addr, sram_wdata} !== {e_ig || e_mg, e_wen, e_addr, e_wd}) begin
                failures++;
                $display("FAIL rnd_sram cyc=%0d en=%b wen=%b addr=%h wdata=%h required %b %b %h %h",
                         c, sram_en, sram_wen, sram_addr, sram_wdata, e_ig || e_mg, e_wen, e_addr, e_wd);
            end
            checks++;
            if ({if_rvalid, mem_rvalid} !== {e_iv, e_mv}) begin
                failures++;
                $display("FAIL rnd_rvalid cyc=%0d if_rvalid=%b mem_rvalid=%b required %b %b", c, if_rvalid, mem_rvalid, e_iv, e_mv);
            end
            checks++;
            if ({if_rdata, mem_rdata} !== {e_ird, e_mrd}) begin
                failures++;
                $display("FAIL rnd_rdata cyc=%0d if_rdata=%h mem_rdata=%h required %h %h", c, if_rdata, mem_rdata, e_ird, e_mrd);
            end
            // Advance the model to the state after the coming rising edge.
            if (e_iv) hi = sram_rdata;
            if (e_mv) hm = sram_rdata;
            st  = (reset && if_req && !e_ig) ? ((st + 1 > SM) ? SM : st + 1) : 0;
            own = e_ig ? 1 : ((e_mg && mem_wen == 4'b0000) ? 2 : 0);
        end
        next_cycle();
        reset = 1'b1;
        idle();
        $display("test_random done cycles=%0d", n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_fetch_read();
        test_starvation();
        test_write_then_read();
        test_alternating();
        test_reset_pending();
        test_fetch_only();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single synchronous SoC SRAM port between the instruction-fetch requester and the data-memory requester.
- Sits between the fetch stage and the SRAM bus, and between the MEM stage and the same bus.
- Data side has fixed priority. A starvation counter forces an instruction grant after STARVE_MAX consecutive denials.
- Tracks ownership of the 1-cycle-latency read return and routes rdata/rvalid back to the owning requester.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive fetch denials before fetch is forced to win; range 1..7

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- mem_req  in  1  data request
- mem_wen  in  4  byte write enables; 0000 = read
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  write data
- mem_gnt  out  1  data request accepted this cycle
- mem_rvalid  out  1  data read data valid
- mem_rdata  out  DATA_W  data read data
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid 1 cycle after an enabled read

Behaviour:
- Grant logic is combinational from the requests and the registered starve count. At most one gnt per cycle.
- Arbitration:
  - mem_req only -> mem wins.
  - if_req only -> if wins.
  - Both -> mem wins, unless starve_cnt == STARVE_MAX, in which case if wins.
- SRAM drive, when if wins: sram_en=1, sram_wen=0000, sram_addr=if_addr, sram_wdata=0.
- SRAM drive, when mem wins: sram_en=1, sram_wen=mem_wen, sram_addr=mem_addr, sram_wdata=mem_wdata.
- SRAM drive, no grant: sram_en=0, sram_wen=0000, sram_addr=0, sram_wdata=0.
- Starve counter (3 bits, registered):
  - +1 (saturating at STARVE_MAX) when if_req && !if_gnt.
  - Clears to 0 when if_gnt or !if_req.
- Response owner register (NONE/IF/MEM), updated every cycle:
  - IF when if_gnt.
  - MEM when mem_gnt && mem_wen==0000.
  - NONE otherwise; writes produce no response.
- if_rvalid = (owner==IF). mem_rvalid = (owner==MEM). Both are registered-state-derived.
- if_rdata = sram_rdata when if_rvalid, else the last value held from a valid cycle. mem_rdata follows the same rule with its own hold register.
- Fully pipelined: a new grant may issue in the same cycle a response returns. Back-to-back reads give 1 result per cycle.
- Write completes at grant; the requester may change inputs the next cycle.
- Reset asserted (any time, including with a response pending):
  - Immediately: owner=NONE, starve_cnt=0, both hold registers=0.
  - All gnt/rvalid/sram_en forced 0 while reset==0.
  - Pending response is discarded.
- Reset values: all outputs 0.
- Requester obligation: hold req/addr stable until gnt. The arbiter does not latch requests.

Decomposition:
- Shared package: owner encoding (OWN_NONE=2'd0, OWN_IF=2'd1, OWN_MEM=2'd2), default STARVE_MAX, WEN_READ=4'b0000.
- One natural sub-module: sram_starve_ctr (saturating counter, inputs inc/clr, output at_max).
- Grant mux, owner register and hold registers stay in the top level.

Test Plan:
- Reset released, if_req=1 with addr 0x0000_0040, mem_req=0 -> if_gnt=1 and sram_addr=0x40 the same cycle; next cycle if_rvalid=1 and if_rdata=sram_rdata (drive 0x2400_0001).
- if_req and mem_req both held 1, mem_wen=0000 -> mem_gnt for cycles 1-4, if_gnt on cycle 5 (STARVE_MAX=4), then mem_gnt again; starve_cnt returns 0 after the if grant.
- mem write 0x1234_5678 to addr 0x100 with wen=0011 -> sram_wen=0011 and sram_wdata passed through; no mem_rvalid the next cycle; a following mem read of 0x100 gets mem_rvalid one cycle later.
- Alternating if/mem reads every cycle -> each rvalid asserts exactly 1 cycle after its own gnt and never on the other side; hold registers keep the last data while rvalid=0.
- Fetch read granted, reset pulled low before the return cycle -> if_rvalid never asserts; after release, all outputs are 0 until a new request.
- if_req=1 alone for 10 cycles -> if_gnt every cycle, starve_cnt stays 0, sram_en=1 constantly.
